// File: rtl/verdict_pkg.sv
// Shared types and constants for the verdict serializer: frame layout, FSM states, index widths.
package verdict_pkg;
  localparam int DEF_NUM_OUT = 3;
  localparam int DEF_DATA_W  = 64;
  localparam int DEF_TS_W    = 32;
  localparam int DEF_DEPTH   = 8;
  localparam int DEF_DROP_W  = 16;

  localparam int IDX_W = (DEF_NUM_OUT > 1) ? $clog2(DEF_NUM_OUT) : 1;
  localparam int LVL_W = $clog2(DEF_DEPTH) + 1;

  typedef struct packed {
    logic [DEF_TS_W-1:0]                      ts;
    logic [DEF_NUM_OUT-1:0]                   aktv;
    logic [DEF_NUM_OUT-1:0][DEF_DATA_W-1:0]   vals;
  } frame_t;

  typedef enum logic {ST_IDLE, ST_EMIT} state_t;

  function automatic logic [IDX_W-1:0] lowest_set(input logic [DEF_NUM_OUT-1:0] m);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = DEF_NUM_OUT - 1; i >= 0; i--) begin
      if (m[i]) r = IDX_W'(i);
    end
    return r;
  endfunction
endpackage

// File: rtl/verdict_serializer_frame_fifo.sv
// Frame FIFO: single-clock, registered level, head visible combinationally on o_dout.
// Push when full and pop when empty are ignored; the caller decides what a refused push means.
module frame_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [W-1:0]             i_din,
  input  logic                     i_pop,
  output logic [W-1:0]             o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_level;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_level == (AW+1)'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_dout    = r_mem[r_rd];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage carries no reset; only pointers and level define validity.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr] <= i_din;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
      if (w_do_push && !w_do_pop)      r_level <= r_level + 1'b1;
      else if (w_do_pop && !w_do_push) r_level <= r_level - 1'b1;
    end
  end
endmodule

// File: rtl/verdict_serializer.sv
// Captures monitor outputs into timestamped frames and drains them as one record per active stream.
// Capture-to-first-record latency is 2 cycles; rec_ready low stalls records, frames overflowing the FIFO are dropped and counted.
module verdict_serializer
  import verdict_pkg::*;
#(
  parameter int NUM_OUT = DEF_NUM_OUT,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TS_W    = DEF_TS_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int DROP_W  = DEF_DROP_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [NUM_OUT*DATA_W-1:0] out_value,
  input  logic [NUM_OUT-1:0]        out_aktv,
  output logic                      rec_valid,
  input  logic                      rec_ready,
  output logic [IDX_W-1:0]          rec_stream,
  output logic [TS_W-1:0]           rec_ts,
  output logic [DATA_W-1:0]         rec_value,
  output logic                      rec_last,
  output logic                      overflow,
  output logic [DROP_W-1:0]         drop_count,
  output logic [LVL_W-1:0]          fifo_level
);
  state_t               r_state;
  frame_t               r_hold;
  logic [TS_W-1:0]      r_ts;

  frame_t               w_cap_frame;
  frame_t               w_head;
  frame_t               w_next_frame;
  logic                 w_cap;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_accept;
  logic                 w_pop;
  logic                 w_load;
  logic [NUM_OUT-1:0]   w_rem;
  logic [NUM_OUT-1:0]   w_next_mask;
  logic [IDX_W-1:0]     w_next_idx;

  assign w_cap       = en && (|out_aktv);
  assign w_cap_frame = {r_ts, out_aktv, out_value};

  frame_fifo #(.W($bits(frame_t)), .DEPTH(DEPTH)) u_fifo (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_push  (w_cap),
    .i_din   (w_cap_frame),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

  // r_hold.aktv doubles as the mask of records still owed for the held frame.
  always_comb begin
    w_accept = rec_valid && rec_ready;
    w_rem    = r_hold.aktv & ~(NUM_OUT'(1) << rec_stream);
    w_pop    = 1'b0;
    case (r_state)
      ST_IDLE: w_pop = !w_empty;
      ST_EMIT: w_pop = w_accept && (w_rem == '0) && !w_empty;
      default: w_pop = 1'b0;
    endcase
    w_load            = w_pop || ((r_state == ST_EMIT) && w_accept && (|w_rem));
    w_next_mask       = w_pop ? w_head.aktv : w_rem;
    w_next_frame      = w_pop ? w_head : r_hold;
    w_next_frame.aktv = w_next_mask;
    w_next_idx        = lowest_set(w_next_mask);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_hold     <= '0;
      r_ts       <= '0;
      rec_valid  <= 1'b0;
      rec_stream <= '0;
      rec_ts     <= '0;
      rec_value  <= '0;
      rec_last   <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (en) r_ts <= r_ts + 1'b1;
      // Fullness is sampled before this edge's pop, so a concurrent drain never saves the frame.
      if (w_cap && w_full) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + 1'b1;
      end
      if (w_load) begin
        r_state    <= ST_EMIT;
        r_hold     <= w_next_frame;
        rec_valid  <= 1'b1;
        rec_stream <= w_next_idx;
        rec_ts     <= w_next_frame.ts;
        rec_value  <= w_next_frame.vals[w_next_idx];
        rec_last   <= $onehot(w_next_mask);
      end else if ((r_state == ST_EMIT) && w_accept) begin
        r_state     <= ST_IDLE;
        r_hold.aktv <= '0;
        rec_valid   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_verdict_serializer.sv
// Directed bench for verdict_serializer; inputs change and outputs are sampled on the falling edge.
module tb_verdict_serializer;
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic [191:0]  out_value = '0;
  logic [2:0]    out_aktv = '0;
  logic          rec_ready = 1'b0;
  logic          rec_valid;
  logic [1:0]    rec_stream;
  logic [31:0]   rec_ts;
  logic [63:0]   rec_value;
  logic          rec_last;
  logic          overflow;
  logic [15:0]   drop_count;
  logic [3:0]    fifo_level;

  int            n_assert = 0;
  int            n_fail = 0;
  logic [31:0]   m_ts = '0;
  logic [31:0]   t0;

  verdict_serializer dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .out_value  (out_value),
    .out_aktv   (out_aktv),
    .rec_valid  (rec_valid),
    .rec_ready  (rec_ready),
    .rec_stream (rec_stream),
    .rec_ts     (rec_ts),
    .rec_value  (rec_value),
    .rec_last   (rec_last),
    .overflow   (overflow),
    .drop_count (drop_count),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rec(input string tag, input int s, input logic [31:0] ts,
                         input logic [63:0] v, input logic last);
    chk({tag, "_valid"}, 64'(rec_valid), 64'd1);
    chk({tag, "_stream"}, 64'(rec_stream), 64'(s));
    chk({tag, "_ts"}, 64'(rec_ts), 64'(ts));
    chk({tag, "_value"}, rec_value, v);
    chk({tag, "_last"}, 64'(rec_last), 64'(last));
  endtask

  // Model timestamp: counts rising edges seen with en high since reset release.
  task automatic tick();
    @(posedge clk);
    if (en && rst) m_ts = m_ts + 1;
    @(negedge clk);
  endtask

  task automatic set_vals(input logic [63:0] v0, input logic [63:0] v1, input logic [63:0] v2);
    out_value = {v2, v1, v0};
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_valid", 64'(rec_valid), 64'd0);
    chk("rst_stream", 64'(rec_stream), 64'd0);
    chk("rst_ts", 64'(rec_ts), 64'd0);
    chk("rst_value", rec_value, 64'd0);
    chk("rst_last", 64'(rec_last), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    en = 1'b1;
    rec_ready = 1'b1;
    m_ts = '0;

    // Single frame at ts=500
    repeat (500) tick();
    out_aktv = 3'b101;
    set_vals(11, 22, 33);
    tick();
    out_aktv = 3'b000;
    chk("single_lat", 64'(rec_valid), 64'd0);
    tick();
    chk_rec("single_r0", 0, 32'd500, 64'd11, 1'b0);
    tick();
    chk_rec("single_r1", 2, 32'd500, 64'd33, 1'b1);
    tick();
    chk("single_end", 64'(rec_valid), 64'd0);

    // Backpressure: 5 stalled cycles
    rec_ready = 1'b0;
    t0 = m_ts;
    out_aktv = 3'b101;
    set_vals(11, 22, 33);
    tick();
    out_aktv = 3'b000;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk_rec("bp_stall", 0, t0, 64'd11, 1'b0);
      chk("bp_level", 64'(fifo_level), 64'd0);
      tick();
    end
    chk_rec("bp_r0", 0, t0, 64'd11, 1'b0);
    rec_ready = 1'b1;
    tick();
    chk_rec("bp_r1", 2, t0, 64'd33, 1'b1);
    tick();
    chk("bp_end", 64'(rec_valid), 64'd0);

    // Overflow: 12 single-stream frames against a stalled consumer
    rec_ready = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      if (i == 10) chk("ovf_before", 64'(overflow), 64'd0);
      out_aktv = 3'b001;
      set_vals(64'(i), 0, 0);
      tick();
    end
    out_aktv = 3'b000;
    chk("ovf_level", 64'(fifo_level), 64'd8);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_drop", 64'(drop_count), 64'd3);
    rec_ready = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      chk("ovf_drain_valid", 64'(rec_valid), 64'd1);
      chk("ovf_drain_value", rec_value, 64'(i));
      chk("ovf_drain_last", 64'(rec_last), 64'd1);
      tick();
    end
    chk("ovf_drained", 64'(rec_valid), 64'd0);
    chk("ovf_level0", 64'(fifo_level), 64'd0);
    chk("ovf_sticky", 64'(overflow), 64'd1);

    // Back-to-back: three full frames, nine gapless records
    t0 = m_ts;
    for (int c = 0; c < 11; c++) begin
      out_aktv = (c < 3) ? 3'b111 : 3'b000;
      set_vals(64'(100 * c), 64'(100 * c + 1), 64'(100 * c + 2));
      if (c >= 2) chk_rec("b2b", (c - 2) % 3, t0 + 32'((c - 2) / 3),
                          64'(100 * ((c - 2) / 3) + (c - 2) % 3), ((c - 2) % 3) == 2);
      tick();
    end
    chk("b2b_end", 64'(rec_valid), 64'd0);

    // en freeze with a pending record
    rec_ready = 1'b0;
    t0 = m_ts;
    out_aktv = 3'b010;
    set_vals(0, 77, 0);
    tick();
    out_aktv = 3'b000;
    tick();
    en = 1'b0;
    out_aktv = 3'b010;
    set_vals(0, 55, 0);
    for (int i = 0; i < 10; i++) begin
      if (i <= 3) chk_rec("frz_hold", 1, t0, 64'd77, 1'b1);
      else chk("frz_idle", 64'(rec_valid), 64'd0);
      chk("frz_level", 64'(fifo_level), 64'd0);
      if (i == 3) rec_ready = 1'b1;
      tick();
    end
    en = 1'b1;
    set_vals(0, 66, 0);
    tick();
    out_aktv = 3'b000;
    tick();
    chk_rec("frz_after", 1, t0 + 32'd2, 64'd66, 1'b1);
    tick();
    chk("frz_end", 64'(rec_valid), 64'd0);

    // Async reset in the middle of EMIT with frames buffered
    rec_ready = 1'b0;
    out_aktv = 3'b111;
    set_vals(1, 2, 3);
    repeat (3) tick();
    out_aktv = 3'b000;
    chk("ar_pre_valid", 64'(rec_valid), 64'd1);
    chk("ar_pre_level", 64'(fifo_level), 64'd2);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_valid", 64'(rec_valid), 64'd0);
    chk("ar_overflow", 64'(overflow), 64'd0);
    chk("ar_drop", 64'(drop_count), 64'd0);
    chk("ar_level", 64'(fifo_level), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    m_ts = '0;
    rec_ready = 1'b1;
    repeat (5) tick();
    out_aktv = 3'b001;
    set_vals(9, 0, 0);
    tick();
    out_aktv = 3'b000;
    tick();
    chk_rec("ar_after", 0, 32'd5, 64'd9, 1'b1);
    tick();
    chk("ar_end", 64'(rec_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/verdict_serializer.md
Name: verdict_serializer

Overview:
- Sits directly downstream of the generated monitor (topEntity).
- Each cycle it captures the monitor's output values and their activation flags, stamps them with a cycle-count timestamp and buffers them as frames in a FIFO.
- It drains the FIFO as a stream of one record per active output over a valid/ready handshake, feeding the trace logger / host link.

Parameters:
- NUM_OUT, 3, number of monitor output streams
- DATA_W, 64, width of each output value (signed, passed through untouched)
- TS_W, 32, timestamp counter width
- DEPTH, 8, frame FIFO depth (power of two, >=2)
- DROP_W, 16, width of dropped-frame counter

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- en  in  1  global enable, same signal as the monitor's en
- out_value  in  NUM_OUT*DATA_W  monitor outputs, stream i at bits [i*DATA_W +: DATA_W]
- out_aktv  in  NUM_OUT  per-stream activation flags from the monitor
- rec_valid  out  1  record available
- rec_ready  in  1  consumer accepts record
- rec_stream  out  clog2(NUM_OUT)  stream index of record
- rec_ts  out  TS_W  timestamp of the frame the record came from
- rec_value  out  DATA_W  output value
- rec_last  out  1  last record of its frame
- overflow  out  1  sticky: at least one frame dropped since reset
- drop_count  out  DROP_W  dropped frames, saturating
- fifo_level  out  clog2(DEPTH)+1  current frame occupancy

Behaviour:
- Reset (rst=0, async): every output is 0, the FIFO is empty, ts counter is 0 and the FSM is IDLE. Deassertion is taken synchronously on the next clk edge.
- Timestamp: ts increments by 1 on every clk edge with en=1 and wraps modulo 2^TS_W. A frame captured in cycle t carries ts(t), the value before that edge's increment.
- Capture: in any cycle with en=1 and |out_aktv, a frame {ts, out_aktv, all values} is pushed at the edge ending that cycle.
  - No frame is pushed when out_aktv==0 or en=0.
- Full rule: fullness is judged on occupancy before that edge's pop.
  - If the FIFO is full, the frame is dropped, overflow is set to 1 (cleared only by reset) and drop_count increments, saturating at all-ones.
  - A simultaneous pop that edge does not rescue the frame.
- FSM states: IDLE, EMIT.
  - IDLE: if the FIFO is non-empty, pop the head into a holding register, set mask=aktv and go to EMIT at the same edge.
  - EMIT: rec_valid=1, rec_stream = lowest set bit of mask, rec_value = that stream's value, rec_ts = frame ts, rec_last=1 iff exactly one mask bit remains.
  - On rec_valid&&rec_ready, clear that mask bit. If it was the last bit and the FIFO is non-empty, pop the next frame at the same edge and stay in EMIT (back-to-back, no bubble). Otherwise go to IDLE.
- Latency: a frame captured in cycle t gives its first rec_valid in cycle t+2 when the FIFO and FSM were idle.
- Record ordering: records within a frame come out in ascending stream index; frames come out in capture order.
- Stall: while rec_valid=1 && rec_ready=0, all rec_* outputs hold stable and rec_valid does not drop.
- en=0: the ts counter and capture freeze. Draining continues, since the handshake is independent of en.
- Reset mid-operation: the held frame and all FIFO contents are discarded, and rec_valid drops asynchronously.
- fifo_level counts buffered frames only, excluding the one in the holding register.

Decomposition:
- Package verdict_pkg holds:
  - the frame typedef (ts, aktv mask, value array);
  - the FSM state enum;
  - the IDX_W and LVL_W constants derived via clog2;
  - a lowest-set-bit priority-encode function.
- One sub-module, frame_fifo: a synchronous FIFO with push/pop, full/empty, level and async active-low reset, parameterised on frame width and DEPTH.

Test Plan:
- Single frame: after reset, hold rst=0 for 2 cycles, then run with en=1 and rec_ready=1. At ts=500 drive out_aktv=3'b101 with values (11,22,33).
  - Required: rec_valid in cycles 502 and 503.
  - Records: (stream 0, ts 500, 11, last=0), then (stream 2, ts 500, 33, last=1). No record for stream 1.
- Backpressure: same frame with rec_ready=0 for 5 cycles, then 1.
  - Required: the first record holds stable during the stall and both records emit after it.
  - fifo_level stays 0, because the frame sits in the holding register.
- Overflow: rec_ready=0, out_aktv=3'b001 for 12 consecutive cycles with values 1..12.
  - Required: fifo_level reaches 8, and 3 frames are dropped (one in the holding register plus 8 buffered).
  - overflow=1, drop_count=3.
  - On release, 9 records drain with values 1..9 in order.
- Back-to-back: three consecutive cycles with out_aktv=3'b111.
  - Required: 9 records on 9 consecutive cycles with rec_ready=1.
  - rec_last is asserted on the 3rd, 6th and 9th records, and rec_valid shows no gap.
- en freeze: en=0 for 10 cycles while out_aktv=3'b010.
  - Required: no frames captured and ts unchanged across the window.
  - The pending record still drains during the window.
- Async reset: assert rst=0 mid-EMIT, between clock edges.
  - Required: rec_valid, overflow, drop_count and fifo_level go to 0 immediately.
  - After release, the first captured frame carries ts=0 plus the elapsed enabled cycles.
